// File: rtl/sdes_round_controller_pkg.sv
// Shared S-DES types, permutation tables and key-schedule helpers.
// Latency: none, pure functions and constants.
// Backpressure: not applicable.
package sdes_pkg;

  typedef enum logic [2:0] {
    IDLE,
    KEYGEN,
    ROUND1,
    ROUND2,
    DONE
  } state_t;

  // S0 indexed [row][col]; row = {n[3],n[0]}, col = {n[2],n[1]}
  localparam logic [1:0] S0_TBL [4][4] = '{
    '{2'd1, 2'd0, 2'd3, 2'd2},
    '{2'd3, 2'd2, 2'd1, 2'd0},
    '{2'd0, 2'd2, 2'd1, 2'd3},
    '{2'd3, 2'd1, 2'd3, 2'd2}
  };

  // Table entries are 1-indexed from the MSB, so position p maps to bit [W-p].
  function automatic logic [9:0] p10(input logic [9:0] k);
    return {k[7], k[5], k[8], k[3], k[6], k[0], k[9], k[1], k[2], k[4]};
  endfunction

  function automatic logic [7:0] p8(input logic [9:0] k);
    return {k[4], k[7], k[3], k[6], k[2], k[5], k[0], k[1]};
  endfunction

  function automatic logic [7:0] ip(input logic [7:0] d);
    return {d[6], d[2], d[5], d[7], d[4], d[0], d[3], d[1]};
  endfunction

  function automatic logic [7:0] ip_inv(input logic [7:0] d);
    return {d[4], d[7], d[5], d[3], d[1], d[6], d[0], d[2]};
  endfunction

  function automatic logic [7:0] ep(input logic [3:0] n);
    return {n[0], n[3], n[2], n[1], n[2], n[1], n[0], n[3]};
  endfunction

  function automatic logic [3:0] p4(input logic [3:0] n);
    return {n[2], n[0], n[1], n[3]};
  endfunction

  // Rotate each 5-bit half left by one.
  function automatic logic [9:0] ls1(input logic [9:0] k);
    return {k[8:5], k[9], k[3:0], k[4]};
  endfunction

  // Rotate each 5-bit half left by two.
  function automatic logic [9:0] ls2(input logic [9:0] k);
    return {k[7:5], k[9:8], k[2:0], k[4:3]};
  endfunction

endpackage

// File: rtl/sdes_round_controller_if.sv
// Host-side block handshake: input block/key/mode and output result.
// Latency: wires only.
// Backpressure: valid/ready on both directions.
interface sdes_round_controller_if;
  logic       inValid;
  logic       inReady;
  logic [7:0] inData;
  logic [9:0] inKey;
  logic       inDecrypt;
  logic       outValid;
  logic       outReady;
  logic [7:0] outData;

  modport master (
    output inValid, inData, inKey, inDecrypt, outReady,
    input  inReady, outValid, outData
  );

  modport slave (
    input  inValid, inData, inKey, inDecrypt, outReady,
    output inReady, outValid, outData
  );
endinterface

// File: rtl/sdes_round_controller_fk.sv
// Combinational S-DES round function Fk plus the S1 lookup it uses.
// Latency: zero cycles.
// Backpressure: none, purely combinational.
module sdes_s1 (
  input  logic [3:0] nib,
  output logic [1:0] val
);
  // Row-major {row,col} flattening of the S1 box.
  localparam logic [1:0] S1_TBL [16] = '{
    2'd0, 2'd1, 2'd2, 2'd3,
    2'd2, 2'd0, 2'd1, 2'd3,
    2'd3, 2'd0, 2'd1, 2'd0,
    2'd2, 2'd1, 2'd0, 2'd3
  };

  // Row is outer bits, column is inner bits.
  always_comb begin
    val = S1_TBL[{nib[3], nib[0], nib[2], nib[1]}];
  end
endmodule

module sdes_fk
  import sdes_pkg::*;
(
  input  logic [7:0] data,
  input  logic [7:0] subkey,
  output logic [7:0] result
);
  logic [7:0] mixed;
  logic [1:0] s0_val;
  logic [1:0] s1_val;

  assign mixed  = ep(data[3:0]) ^ subkey;
  assign s0_val = S0_TBL[{mixed[7], mixed[4]}][{mixed[6], mixed[5]}];

  sdes_s1 u_s1 (
    .nib (mixed[3:0]),
    .val (s1_val)
  );

  // Only the left nibble is altered; the right nibble passes through.
  assign result = {data[7:4] ^ p4({s0_val, s1_val}), data[3:0]};
endmodule

// File: rtl/sdes_round_controller.sv
// Iterative S-DES controller sharing one Fk datapath across both rounds.
// Latency: 3 edges accept-to-valid, 2 when the cached key schedule is reused.
// Backpressure: accepts only in IDLE; result held in DONE until outReady.
module sdes_round_controller
  import sdes_pkg::*;
#(
  parameter int KEY_REUSE = 1,
  parameter int BLK_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rstN,
  sdes_round_controller_if.slave bus,
  output logic                 busy,
  output logic [BLK_CNT_W-1:0] blockCount
);
  state_t state;
  state_t next_state;

  logic [7:0]           data_q;
  logic [9:0]           key_q;
  logic                 dec_q;
  logic [7:0]           k1_q;
  logic [7:0]           k2_q;
  logic [9:0]           key_cache;
  logic                 cache_vld;
  logic [7:0]           mid_q;
  logic [7:0]           out_data_q;
  logic                 out_valid_q;
  logic [BLK_CNT_W-1:0] cnt_q;
  logic                 in_ready;
  logic                 key_hit;

  logic [9:0] ks_shift1;
  logic [7:0] k1_next;
  logic [7:0] k2_next;
  logic [7:0] fk_in;
  logic [7:0] fk_key;
  logic [7:0] fk_out;

  assign key_hit   = (KEY_REUSE != 0) && cache_vld && (bus.inKey == key_cache);
  assign ks_shift1 = ls1(p10(key_q));
  assign k1_next   = p8(ks_shift1);
  assign k2_next   = p8(ls2(ks_shift1));

  // Round 1 uses the first subkey of the mode's order; decrypt swaps the order.
  assign fk_in  = (state == ROUND1) ? ip(data_q) : mid_q;
  assign fk_key = ((state == ROUND1) ^ dec_q) ? k1_q : k2_q;

  sdes_fk u_fk (
    .data   (fk_in),
    .subkey (fk_key),
    .result (fk_out)
  );

  // State register.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state and handshake decode.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.inValid) next_state = key_hit ? ROUND1 : KEYGEN;
      end
      KEYGEN: next_state = ROUND1;
      ROUND1: next_state = ROUND2;
      ROUND2: next_state = DONE;
      DONE:   if (bus.outReady) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Block capture, key schedule, round results and completion count.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      data_q      <= '0;
      key_q       <= '0;
      dec_q       <= 1'b0;
      k1_q        <= '0;
      k2_q        <= '0;
      key_cache   <= '0;
      cache_vld   <= 1'b0;
      mid_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.inValid) begin
            data_q <= bus.inData;
            key_q  <= bus.inKey;
            dec_q  <= bus.inDecrypt;
          end
        end
        KEYGEN: begin
          k1_q      <= k1_next;
          k2_q      <= k2_next;
          key_cache <= key_q;
          cache_vld <= 1'b1;
        end
        ROUND1: mid_q <= {fk_out[3:0], fk_out[7:4]};
        ROUND2: begin
          out_data_q  <= ip_inv(fk_out);
          out_valid_q <= 1'b1;
        end
        DONE: begin
          if (bus.outReady) begin
            out_valid_q <= 1'b0;
            cnt_q       <= cnt_q + BLK_CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.inReady  = in_ready;
  assign bus.outValid = out_valid_q;
  assign bus.outData  = out_data_q;
  assign busy         = (state != IDLE);
  assign blockCount   = cnt_q;
endmodule

// File: tb/tb_sdes_round_controller.sv
// Directed bench for sdes_round_controller: three instances (key reuse on,
// key reuse off, 2-bit counter) share stimulus; sel routes inValid and the
// observed outputs to one instance at a time.
`timescale 1ns/1ps
module tb_sdes_round_controller;
  import sdes_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic [9:0] in_key = 10'h000;
  logic       in_dec = 1'b0;
  logic       out_ready = 1'b0;
  int         sel = 0;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  sdes_round_controller_if ifa ();
  sdes_round_controller_if ifb ();
  sdes_round_controller_if ifc ();

  assign ifa.inValid = in_valid && (sel == 0);
  assign ifb.inValid = in_valid && (sel == 1);
  assign ifc.inValid = in_valid && (sel == 2);
  assign ifa.inData = in_data;  assign ifb.inData = in_data;  assign ifc.inData = in_data;
  assign ifa.inKey = in_key;    assign ifb.inKey = in_key;    assign ifc.inKey = in_key;
  assign ifa.inDecrypt = in_dec; assign ifb.inDecrypt = in_dec; assign ifc.inDecrypt = in_dec;
  assign ifa.outReady = out_ready; assign ifb.outReady = out_ready; assign ifc.outReady = out_ready;

  logic        busy_a, busy_b, busy_c;
  logic [15:0] cnt_a, cnt_b;
  logic [1:0]  cnt_c;

  sdes_round_controller #(.KEY_REUSE(1), .BLK_CNT_W(16)) dut_a (
    .clk(clk), .rstN(rst_n), .bus(ifa), .busy(busy_a), .blockCount(cnt_a));
  sdes_round_controller #(.KEY_REUSE(0), .BLK_CNT_W(16)) dut_b (
    .clk(clk), .rstN(rst_n), .bus(ifb), .busy(busy_b), .blockCount(cnt_b));
  sdes_round_controller #(.KEY_REUSE(1), .BLK_CNT_W(2)) dut_c (
    .clk(clk), .rstN(rst_n), .bus(ifc), .busy(busy_c), .blockCount(cnt_c));

  logic        o_rdy, o_vld, o_busy;
  logic [7:0]  o_dat;
  logic [15:0] o_cnt;

  always_comb begin
    o_rdy = ifa.inReady; o_vld = ifa.outValid; o_dat = ifa.outData;
    o_busy = busy_a; o_cnt = cnt_a;
    if (sel == 1) begin
      o_rdy = ifb.inReady; o_vld = ifb.outValid; o_dat = ifb.outData;
      o_busy = busy_b; o_cnt = cnt_b;
    end else if (sel == 2) begin
      o_rdy = ifc.inReady; o_vld = ifc.outValid; o_dat = ifc.outData;
      o_busy = busy_c; o_cnt = {14'd0, cnt_c};
    end
  end

  // Offer a block, wait for the accept edge, then count edges until outValid.
  task automatic do_block(input logic [7:0] d, input logic [9:0] k, input logic dec,
                          output int lat, output logic [7:0] res);
    int n;
    @(negedge clk);
    in_data = d; in_key = k; in_dec = dec; in_valid = 1'b1;
    n = 0;
    while (!o_rdy && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!o_vld && lat < 10) begin @(posedge clk); #1; lat++; end
    res = o_dat;
  endtask

  task automatic test_reset();
    sel = 0; rst_n = 1'b0;
    repeat (2) @(posedge clk); #1;
    checks++; if (o_rdy !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", o_rdy); end
    checks++; if (o_vld !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", o_vld); end
    checks++; if (o_dat !== 8'h00) begin errors++; $display("FAIL reset_out_data got %h want 00", o_dat); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", o_busy); end
    checks++; if (o_cnt !== 16'd0) begin errors++; $display("FAIL reset_count got %0d want 0", o_cnt); end
    checks++; if (dut_a.k1_q !== 8'h00 || dut_a.k2_q !== 8'h00) begin
      errors++; $display("FAIL reset_subkeys got %h/%h want 00/00", dut_a.k1_q, dut_a.k2_q); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_encrypt();
    int lat; logic [7:0] res;
    sel = 0; out_ready = 1'b1;
    do_block(8'h97, 10'h282, 1'b0, lat, res);
    checks++; if (lat !== 3) begin errors++; $display("FAIL enc_latency got %0d want 3", lat); end
    checks++; if (res !== 8'h38) begin errors++; $display("FAIL enc_data got %h want 38", res); end
    checks++; if (dut_a.k1_q !== 8'hA4) begin errors++; $display("FAIL enc_k1 got %h want a4", dut_a.k1_q); end
    checks++; if (dut_a.k2_q !== 8'h43) begin errors++; $display("FAIL enc_k2 got %h want 43", dut_a.k2_q); end
    @(posedge clk); #1;
    checks++; if (o_cnt !== 16'd1) begin errors++; $display("FAIL enc_count got %0d want 1", o_cnt); end
    checks++; if (o_vld !== 1'b0) begin errors++; $display("FAIL enc_valid_drop got %0b want 0", o_vld); end
  endtask

  task automatic test_key_reuse();
    int lat; logic [7:0] res;
    sel = 0; out_ready = 1'b1;
    do_block(8'h97, 10'h282, 1'b0, lat, res);
    checks++; if (lat !== 2) begin errors++; $display("FAIL reuse_enc_latency got %0d want 2", lat); end
    checks++; if (res !== 8'h38) begin errors++; $display("FAIL reuse_enc_data got %h want 38", res); end
    @(posedge clk); #1;
    do_block(8'h38, 10'h282, 1'b1, lat, res);
    checks++; if (lat !== 2) begin errors++; $display("FAIL reuse_dec_latency got %0d want 2", lat); end
    checks++; if (res !== 8'h97) begin errors++; $display("FAIL reuse_dec_data got %h want 97", res); end
    @(posedge clk); #1;
    checks++; if (o_cnt !== 16'd3) begin errors++; $display("FAIL reuse_count got %0d want 3", o_cnt); end
  endtask

  task automatic test_no_reuse();
    int lat; logic [7:0] res;
    sel = 1; out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      do_block(8'h97, 10'h282, 1'b0, lat, res);
      checks++; if (lat !== 3) begin errors++; $display("FAIL noreuse_latency[%0d] got %0d want 3", i, lat); end
      checks++; if (res !== 8'h38) begin errors++; $display("FAIL noreuse_data[%0d] got %h want 38", i, res); end
      @(posedge clk); #1;
    end
    checks++; if (o_cnt !== 16'd2) begin errors++; $display("FAIL noreuse_count got %0d want 2", o_cnt); end
  endtask

  task automatic test_decrypt_cold();
    int lat; logic [7:0] res;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    sel = 0; out_ready = 1'b1;
    do_block(8'h38, 10'h282, 1'b1, lat, res);
    checks++; if (lat !== 3) begin errors++; $display("FAIL dec_latency got %0d want 3", lat); end
    checks++; if (res !== 8'h97) begin errors++; $display("FAIL dec_data got %h want 97", res); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int lat; logic [7:0] res; logic [15:0] cnt0;
    sel = 0; out_ready = 1'b0;
    cnt0 = o_cnt;
    do_block(8'h97, 10'h282, 1'b0, lat, res);
    checks++; if (res !== 8'h38) begin errors++; $display("FAIL bp_data got %h want 38", res); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 8'h55; in_key = 10'h3FF; in_dec = 1'b1;
      @(posedge clk); #1;
      checks++; if (o_vld !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got %0b want 1", i, o_vld); end
      checks++; if (o_dat !== 8'h38) begin errors++; $display("FAIL bp_hold[%0d] got %h want 38", i, o_dat); end
      checks++; if (o_rdy !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d] got %0b want 0", i, o_rdy); end
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    checks++; if (o_rdy !== 1'b0) begin errors++; $display("FAIL bp_no_same_cycle_accept got %0b want 0", o_rdy); end
    @(posedge clk); #1;
    checks++; if (o_vld !== 1'b0) begin errors++; $display("FAIL bp_release_valid got %0b want 0", o_vld); end
    checks++; if (o_cnt !== cnt0 + 16'd1) begin errors++; $display("FAIL bp_count got %0d want %0d", o_cnt, cnt0 + 16'd1); end
    checks++; if (o_rdy !== 1'b1) begin errors++; $display("FAIL bp_ready_return got %0b want 1", o_rdy); end
    repeat (2) @(posedge clk); #1;
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL bp_ignored_input got busy %0b want 0", o_busy); end
  endtask

  task automatic test_reset_midop();
    int lat; logic [7:0] res; bit saw_vld;
    sel = 0; out_ready = 1'b1;
    @(negedge clk);
    in_data = 8'h97; in_key = 10'h282; in_dec = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (dut_a.state !== ROUND1) begin errors++; $display("FAIL midop_in_round1 got %0d want %0d", dut_a.state, ROUND1); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (o_vld !== 1'b0) begin errors++; $display("FAIL midop_valid got %0b want 0", o_vld); end
    checks++; if (o_rdy !== 1'b1) begin errors++; $display("FAIL midop_ready got %0b want 1", o_rdy); end
    checks++; if (o_cnt !== 16'd0) begin errors++; $display("FAIL midop_count got %0d want 0", o_cnt); end
    @(negedge clk); rst_n = 1'b1;
    saw_vld = 1'b0;
    repeat (4) begin @(posedge clk); #1; if (o_vld) saw_vld = 1'b1; end
    checks++; if (saw_vld !== 1'b0) begin errors++; $display("FAIL midop_discard got output %0b want none", saw_vld); end
    do_block(8'h97, 10'h282, 1'b0, lat, res);
    checks++; if (lat !== 3) begin errors++; $display("FAIL midop_cold_latency got %0d want 3", lat); end
    checks++; if (res !== 8'h38) begin errors++; $display("FAIL midop_data got %h want 38", res); end
    @(posedge clk); #1;
  endtask

  task automatic test_count_wrap();
    int lat; logic [7:0] res;
    logic [15:0] exp_cnt [5];
    exp_cnt = '{16'd1, 16'd2, 16'd3, 16'd0, 16'd1};
    sel = 2; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      do_block(8'h97, 10'h282, 1'b0, lat, res);
      @(posedge clk); #1;
      checks++; if (o_cnt !== exp_cnt[i]) begin errors++; $display("FAIL wrap_count[%0d] got %0d want %0d", i, o_cnt, exp_cnt[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_encrypt();
    test_key_reuse();
    test_no_reuse();
    test_decrypt_cold();
    test_backpressure();
    test_reset_midop();
    test_count_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/sdes_round_controller.md
Name: sdes_round_controller

Overview:
Iterative S-DES engine controller. Accepts one 8-bit block, a 10-bit key and a mode bit over a valid/ready handshake. Generates subkeys K1/K2 and time-shares a single Fk round datapath (EP, key XOR, S0/S1, P4) across both rounds. Returns the result over a valid/ready handshake. Sits between the host-side block interface and the S-box/Fk datapath.

Parameters:
KEY_REUSE, 1, 1 = skip the KEYGEN state when inKey equals the cached key (cache valid); 0 = always run KEYGEN
BLK_CNT_W, 16, width of the completed-block counter

Ports:
clk  input  1  single clock, rising edge
rstN  input  1  reset, asynchronous, active-low
inValid  input  1  input block valid
inReady  output  1  controller can accept a block
inData  input  8  plaintext or ciphertext, bit 7 = S-DES bit 1
inKey  input  10  key, bit 9 = S-DES bit 1
inDecrypt  input  1  1 = decrypt (subkey order K2,K1), 0 = encrypt (K1,K2)
outValid  output  1  outData valid
outReady  input  1  consumer accepts outData
outData  output  8  result block
busy  output  1  high in any state other than IDLE
blockCount  output  BLK_CNT_W  number of completed output handshakes, wraps

Behaviour:
- Reset (async assert, sync deassert by design): state=IDLE; inReady=1; outValid=0; outData=0; busy=0; blockCount=0; subkey registers=0; key cache invalid.
- Asserting reset mid-operation discards the in-flight block; no output is produced for it.
- FSM states: IDLE, KEYGEN, ROUND1, ROUND2, DONE.
- IDLE: inReady=1. On inValid&&inReady, register inData, inKey and inDecrypt.
  - Next state is ROUND1 if KEY_REUSE=1, cache valid and inKey==cached key; otherwise KEYGEN.
- KEYGEN (1 cycle): P10, then LS-1 on each 5-bit half, then P8 gives K1; a further LS-2 on each half, then P8 gives K2. Register both subkeys, store the key, set cache valid. Next state ROUND1.
- ROUND1 (1 cycle): x = IP(data); y = Fk(x, first subkey); register SW(y). Next state ROUND2.
- ROUND2 (1 cycle): z = Fk(reg, second subkey); outData <= IP^-1(z); outValid <= 1. Next state DONE.
- DONE: outValid=1 and outData held stable until outReady. On outReady:
  - outValid <= 0, blockCount += 1 (wraps modulo 2^BLK_CNT_W), next state IDLE.
  - inReady returns high on the following cycle; there is no same-cycle accept in DONE.
- Latency from the accept edge to outValid=1: 3 edges with KEYGEN, 2 edges on key reuse.
- inReady=0 in every state except IDLE. Input changes while not ready are ignored.
- Fk(L,R) = (L XOR P4(S0(a) ++ S1(b)), R), where {a,b} = EP(R) XOR subkey.
- S-box addressing: for a 4-bit nibble n[3:0], row = {n[3],n[0]} and column = {n[2],n[1]}.
  - S0 rows: 1 0 3 2 / 3 2 1 0 / 0 2 1 3 / 3 1 3 2.
  - S1 rows: 0 1 2 3 / 2 0 1 3 / 3 0 1 0 / 2 1 0 3.
- Tables (1-indexed from MSB): P10=3 5 2 7 4 10 1 9 8 6; P8=6 3 7 4 8 5 10 9; IP=2 6 3 1 4 8 5 7; IP^-1=4 1 3 5 7 2 8 6; EP=4 1 2 3 2 3 4 1; P4=2 4 3 1.

Decomposition:
- Package sdes_pkg holds:
  - the state enum;
  - permutation functions p10, p8, ip, ip_inv, ep, p4;
  - the ls1/ls2 helpers;
  - the S0 table constant.
- One sub-module, sdes_fk: combinational Fk, with 8-bit data, 8-bit subkey and 8-bit result. It instantiates S0 logic and the existing S1 module.
- The controller instantiates exactly one sdes_fk and muxes its subkey input by state and mode.

Test Plan:
- Encrypt: key 1010000010, data 10010111, mode 0, outReady=1 -> K1=10100100, K2=01000011; outData=00111000 three edges after accept; blockCount=1.
- Decrypt: same key, data 00111000, mode 1, issued after reset (cache cold) -> outData=10010111 at latency 3.
- Key reuse: with KEY_REUSE=1, a second encrypt of 10010111 under key 1010000010 -> outData=00111000 at latency 2. With KEY_REUSE=0 the same sequence gives latency 3.
- Backpressure: outReady=0 for 5 cycles after outValid -> outValid and outData stay stable, inReady stays 0, and a new inValid is ignored. Raising outReady gives blockCount+1, then inReady=1 on the next cycle.
- Reset mid-op: assert rstN=0 during ROUND1 -> outValid=0, inReady=1, blockCount=0 immediately; the next block runs KEYGEN (cache invalidated).
- Counter wrap: BLK_CNT_W=2, complete 5 blocks -> blockCount sequence 1,2,3,0,1.
